// File: rtl/data_route_sched.sv
// -----------------------------------------------------------------------------
// data_route_sched
//
// Per-command scheduler for the f -> {A/B | C/D} data route. It accepts one
// command at a time, selects the route mode, and opens the upstream gate for
// exactly the number of f beats the command asks for. In wide mode (1) it
// also waits for count/4 beats on the 6144-bit C stream before reporting
// completion.
//
// Command flow:
//   IDLE  -> SETUP : valid command accepted; mode and counters loaded
//   SETUP -> RUN   : one dead cycle so mode is stable before traffic; gate opens
//   RUN   -> DRAIN : last f beat taken while C beats are still outstanding
//   RUN   -> DONE  : last f beat taken and no C beats outstanding
//   DRAIN -> DONE  : last outstanding C beat taken
//   DONE  -> IDLE  : done pulses for this one cycle
// A zero-length command goes straight from IDLE to DONE. A wide command whose
// count is not a multiple of 4 is rejected with an err pulse. abort in
// SETUP/RUN/DRAIN drops the command and pulses err.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous active-high reset
//   cmd_tdata   [CNT_W] = requested mode, [CNT_W-1:0] = f beat count
//   cmd_tvalid  command valid
//   cmd_tready  command ready, high exactly while IDLE
//   f_fire      one accepted beat on the f input stream
//   c_fire      one accepted beat on the C output stream
//   abort       cancel the current command
//   mode        registered route select (0 = A/B split, 1 = C/D wide)
//   gate_en     registered qualifier for upstream f/g/h tvalid
//   busy        high in every state other than IDLE
//   done        one-cycle completion pulse
//   err         one-cycle pulse for a rejected or aborted command
//   beats_left  f beats still owed by the current command
// -----------------------------------------------------------------------------
module data_route_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W:0]   cmd_tdata,
  input  logic             cmd_tvalid,
  output logic             cmd_tready,
  input  logic             f_fire,
  input  logic             c_fire,
  input  logic             abort,
  output logic             mode,
  output logic             gate_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] beats_left
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t           state_q,   state_d;
  logic             mode_q,    mode_d;
  logic             gate_en_q, gate_en_d;
  logic             done_q,    done_d;
  logic             err_q,     err_d;
  logic [CNT_W-1:0] f_left_q,  f_left_d;
  logic [CNT_W-1:0] c_left_q,  c_left_d;

  // Command fields and handshake.
  logic             cmd_mode;
  logic [CNT_W-1:0] cmd_cnt;
  logic             cmd_accept;

  assign cmd_mode   = cmd_tdata[CNT_W];
  assign cmd_cnt    = cmd_tdata[CNT_W-1:0];
  assign cmd_accept = cmd_tvalid && (state_q == ST_IDLE);

  // Beat accounting. f beats only count while the gate is open (RUN); C beats
  // count in RUN and DRAIN. Neither counter is allowed to wrap below zero, so
  // stray pulses in other states or after a counter has emptied are dropped.
  logic             f_dec;
  logic             c_dec;
  logic             f_last;
  logic [CNT_W-1:0] f_left_nxt;
  logic [CNT_W-1:0] c_left_nxt;

  assign f_dec      = f_fire && (state_q == ST_RUN) && (f_left_q != '0);
  assign c_dec      = c_fire && ((state_q == ST_RUN) || (state_q == ST_DRAIN))
                      && (c_left_q != '0);
  assign f_last     = f_dec && (f_left_q == CNT_W'(1));
  assign f_left_nxt = f_dec ? (f_left_q - CNT_W'(1)) : f_left_q;
  assign c_left_nxt = c_dec ? (c_left_q - CNT_W'(1)) : c_left_q;

  // abort only matters while a command is actually in flight.
  logic abort_hit;
  assign abort_hit = abort &&
                     ((state_q == ST_SETUP) || (state_q == ST_RUN) || (state_q == ST_DRAIN));

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every target is given a default first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    mode_d    = mode_q;
    gate_en_d = gate_en_q;
    f_left_d  = f_left_q;
    c_left_d  = c_left_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (abort_hit) begin
      state_d   = ST_IDLE;
      gate_en_d = 1'b0;
      f_left_d  = '0;
      c_left_d  = '0;
      err_d     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_accept) begin
            if (cmd_cnt == '0) begin
              // Empty command: complete without touching mode or the gate.
              state_d  = ST_DONE;
              done_d   = 1'b1;
              f_left_d = '0;
              c_left_d = '0;
            end else if (cmd_mode && (cmd_cnt[1:0] != 2'b00)) begin
              // Wide path moves 4 f beats per C beat; a remainder cannot be
              // drained, so the command is refused and nothing changes.
              err_d = 1'b1;
            end else begin
              state_d  = ST_SETUP;
              mode_d   = cmd_mode;
              f_left_d = cmd_cnt;
              c_left_d = cmd_mode ? (cmd_cnt >> 2) : '0;
            end
          end
        end

        ST_SETUP: begin
          // mode has been stable for this cycle; traffic may start next.
          state_d   = ST_RUN;
          gate_en_d = 1'b1;
        end

        ST_RUN: begin
          f_left_d = f_left_nxt;
          c_left_d = c_left_nxt;
          if (f_last) begin
            // Close the gate on the edge that takes the final beat so the
            // upstream never sees a valid for a beat we do not want.
            gate_en_d = 1'b0;
            if (c_left_nxt != '0) begin
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          c_left_d = c_left_nxt;
          if (c_left_nxt == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end

        ST_DONE: begin
          state_d = ST_IDLE;
        end

        default: begin
          state_d   = ST_IDLE;
          gate_en_d = 1'b0;
          f_left_d  = '0;
          c_left_d  = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      gate_en_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      f_left_q  <= '0;
      c_left_q  <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      gate_en_q <= gate_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
      f_left_q  <= f_left_d;
      c_left_q  <= c_left_d;
    end
  end

  // done_q is set on the edge entering DONE, so it is high exactly while the
  // FSM sits in DONE; err_q is set on the edge that rejects or aborts.
  assign cmd_tready = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign mode       = mode_q;
  assign gate_en    = gate_en_q;
  assign done       = done_q;
  assign err        = err_q;
  assign beats_left = f_left_q;

endmodule

// File: tb/tb_data_route_sched.sv
// -----------------------------------------------------------------------------
// tb_data_route_sched
//
// Bench for data_route_sched. Directed scenarios cover the command flows
// (narrow, wide with drain, rejected, empty, abort, reset in flight), then a
// randomized run issues commands with random beat timing. Every done/err
// pulse is matched by a monitor against a queue of expected completion
// events (kind, mode, cycle) that the stimulus side predicts from the
// command-level rules: a command finishes one cycle after its last required
// beat is taken, is refused one cycle after acceptance, or is cancelled one
// cycle after abort.
// -----------------------------------------------------------------------------
module tb_data_route_sched;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic [CNT_W:0]   cmd_tdata;
  logic             cmd_tvalid;
  logic             cmd_tready;
  logic             f_fire;
  logic             c_fire;
  logic             abort;
  logic             mode;
  logic             gate_en;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] beats_left;

  data_route_sched #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_tdata  (cmd_tdata),
    .cmd_tvalid (cmd_tvalid),
    .cmd_tready (cmd_tready),
    .f_fire     (f_fire),
    .c_fire     (c_fire),
    .abort      (abort),
    .mode       (mode),
    .gate_en    (gate_en),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .beats_left (beats_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge counter; read on falling edges so it is always settled.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          is_err;
    bit          mode;
    int unsigned at;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  function automatic void push_exp(input bit is_err, input bit m, input int unsigned at);
    exp_t e;
    e.is_err = is_err;
    e.mode   = m;
    e.at     = at;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (done || err) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: done=%0b err=%0b at cycle %0d, expected no event",
                 done, err, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind",  {30'd0, done, err}, mon_e.is_err ? 32'd1 : 32'd2);
        check("event_mode",  {31'd0, mode}, {31'd0, mon_e.mode});
        check("event_cycle", cyc, mon_e.at);
        check("event_beats_left", {16'd0, beats_left}, 32'd0);
        check("event_gate_en", {31'd0, gate_en}, 32'd0);
        check("event_busy",  {31'd0, busy}, mon_e.is_err ? 32'd0 : 32'd1);
      end
    end
  end

  // Watchdog: the run is far shorter than this.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called at a falling edge)
  // ---------------------------------------------------------------------------
  bit model_mode = 1'b0;

  // Present a command for one cycle; returns the cycle it was driven in.
  task automatic drive_cmd(input bit m, input int cnt, output int unsigned n);
    n          = cyc;
    cmd_tdata  = {m, CNT_W'(cnt)};
    cmd_tvalid = 1'b1;
    @(negedge clk);
    cmd_tvalid = 1'b0;
    cmd_tdata  = '0;
  endtask

  // Upstream that always has data: a beat is taken whenever the gate is open.
  task automatic run_f(input int cycles, output int gate_cycles);
    gate_cycles = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (gate_en) gate_cycles++;
      f_fire = gate_en;
    end
    f_fire = 1'b0;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!cmd_tready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_tready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: cmd_tready=%0b after %0d cycles, expected 1", cmd_tready, w);
    end
  endtask

  // One random command with random beat timing and an occasional abort.
  task automatic rand_cmd();
    bit          m;
    int          cnt;
    int          abort_j;
    int          need_c;
    int          f_sent;
    int          c_got;
    bit          ff;
    bit          cf;
    bit          fin;
    int unsigned n0;

    m = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0:       cnt = 0;
      1, 2:    cnt = int'($urandom_range(1, 20));
      default: cnt = m ? 4 * int'($urandom_range(1, 6)) : int'($urandom_range(1, 24));
    endcase
    abort_j = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 12)) : -1;

    wait_ready();
    if (cnt == 0) begin
      push_exp(1'b0, model_mode, cyc + 1);
      drive_cmd(m, cnt, n0);
      // In DONE: abort and C beats must both be ignored.
      abort  = 1'($urandom_range(0, 1));
      c_fire = 1'($urandom_range(0, 1));
      @(negedge clk);
      abort  = 1'b0;
      c_fire = 1'b0;
    end else if (m && (cnt % 4 != 0)) begin
      push_exp(1'b1, model_mode, cyc + 1);
      drive_cmd(m, cnt, n0);
    end else begin
      model_mode = m;
      need_c     = m ? cnt / 4 : 0;
      f_sent     = 0;
      c_got      = 0;
      fin        = 1'b0;
      drive_cmd(m, cnt, n0);
      // j = 0 is the SETUP cycle; from j = 1 the command is in RUN or DRAIN.
      for (int j = 0; j < 400 && !fin; j++) begin
        if (j > 0) @(negedge clk);
        if (j == abort_j) begin
          push_exp(1'b1, m, cyc + 1);
          abort  = 1'b1;
          f_fire = 1'b0;
          c_fire = 1'($urandom_range(0, 1));
          @(negedge clk);
          abort  = 1'b0;
          c_fire = 1'b0;
          fin    = 1'b1;
        end else if (j == 0) begin
          f_fire = 1'b0;
          c_fire = 1'($urandom_range(0, 1));
        end else begin
          ff = (f_sent < cnt) && ($urandom_range(0, 3) != 0);
          cf = 1'($urandom_range(0, 1));
          if (ff) f_sent++;
          if (cf && c_got < need_c) c_got++;
          f_fire = ff;
          c_fire = cf;
          if (f_sent == cnt && c_got == need_c) begin
            push_exp(1'b0, m, cyc + 1);
            @(negedge clk);
            f_fire = 1'b0;
            c_fire = 1'($urandom_range(0, 1));
            abort  = 1'($urandom_range(0, 1));
            @(negedge clk);
            abort  = 1'b0;
            c_fire = 1'b0;
            fin    = 1'b1;
          end
        end
      end
      f_fire = 1'b0;
      c_fire = 1'b0;
      if (!fin) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rand_stall: command mode=%0b count=%0d did not complete", m, cnt);
      end
    end

    repeat ($urandom_range(0, 2)) begin
      c_fire = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    c_fire = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int unsigned n0;
    int          gc;
    int          ev;

    rst        = 1'b1;
    cmd_tdata  = '0;
    cmd_tvalid = 1'b0;
    f_fire     = 1'b0;
    c_fire     = 1'b0;
    abort      = 1'b0;

    // Reset values.
    @(negedge clk);
    @(negedge clk);
    check("rst_mode",    {31'd0, mode}, 32'd0);
    check("rst_gate_en", {31'd0, gate_en}, 32'd0);
    check("rst_done",    {31'd0, done}, 32'd0);
    check("rst_err",     {31'd0, err}, 32'd0);
    check("rst_beats",   {16'd0, beats_left}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready",   {31'd0, cmd_tready}, 32'd1);
    check("rst_busy",    {31'd0, busy}, 32'd0);

    // Narrow command, 3 beats, upstream always ready.
    drive_cmd(1'b0, 3, n0);
    push_exp(1'b0, 1'b0, n0 + 5);
    check("narrow_setup_gate",  {31'd0, gate_en}, 32'd0);
    check("narrow_setup_busy",  {31'd0, busy}, 32'd1);
    check("narrow_setup_beats", {16'd0, beats_left}, 32'd3);
    run_f(7, gc);
    check("narrow_gate_cycles", gc, 32'd3);
    check("narrow_mode", {31'd0, mode}, 32'd0);

    // Wide command with a count that is not a multiple of 4: refused.
    push_exp(1'b1, model_mode, cyc + 1);
    drive_cmd(1'b1, 6, n0);
    check("reject_ready", {31'd0, cmd_tready}, 32'd1);
    check("reject_mode",  {31'd0, mode}, 32'd0);
    check("reject_busy",  {31'd0, busy}, 32'd0);

    // Wide command, 8 f beats, 2 C beats arriving late: drains before done.
    model_mode = 1'b1;
    drive_cmd(1'b1, 8, n0);
    push_exp(1'b0, 1'b1, n0 + 16);
    gc = 0;
    for (int j = 1; j <= 18; j++) begin
      if (j > 1) @(negedge clk);
      if (j == 1) begin
        check("wide_setup_mode",  {31'd0, mode}, 32'd1);
        check("wide_setup_gate",  {31'd0, gate_en}, 32'd0);
        check("wide_setup_beats", {16'd0, beats_left}, 32'd8);
      end
      if (gate_en) gc++;
      if (j >= 10 && j <= 15) check("wide_drain", {29'd0, busy, gate_en, done}, 32'd4);
      f_fire = (j >= 2 && j <= 9);
      c_fire = (j == 14 || j == 15);
    end
    f_fire = 1'b0;
    c_fire = 1'b0;
    check("wide_gate_cycles", gc, 32'd8);
    check("wide_mode_kept", {31'd0, mode}, 32'd1);

    // Empty command: done, gate never opens, mode untouched.
    push_exp(1'b0, model_mode, cyc + 1);
    drive_cmd(1'b0, 0, n0);
    gc = gate_en ? 1 : 0;
    repeat (3) begin
      @(negedge clk);
      if (gate_en) gc++;
    end
    check("empty_gate_cycles", gc, 32'd0);
    check("empty_mode", {31'd0, mode}, 32'd1);

    // Abort after 2 of 4 beats.
    model_mode = 1'b0;
    drive_cmd(1'b0, 4, n0);
    push_exp(1'b1, 1'b0, n0 + 5);
    @(negedge clk);
    f_fire = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_beats", {16'd0, beats_left}, 32'd2);
    check("abort_pre_gate",  {31'd0, gate_en}, 32'd1);
    f_fire = 1'b0;
    abort  = 1'b1;
    @(negedge clk);
    abort  = 1'b0;
    check("abort_gate",  {31'd0, gate_en}, 32'd0);
    check("abort_beats", {16'd0, beats_left}, 32'd0);
    check("abort_ready", {31'd0, cmd_tready}, 32'd1);

    // Reset while a wide command is running.
    model_mode = 1'b1;
    drive_cmd(1'b1, 8, n0);
    @(negedge clk);
    f_fire = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rstrun_pre_gate", {31'd0, gate_en}, 32'd1);
    check("rstrun_pre_mode", {31'd0, mode}, 32'd1);
    f_fire = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rstrun_mode",  {31'd0, mode}, 32'd0);
    check("rstrun_gate",  {31'd0, gate_en}, 32'd0);
    check("rstrun_beats", {16'd0, beats_left}, 32'd0);
    model_mode = 1'b0;
    ev = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || err) ev++;
    end
    check("rstrun_no_pulse", ev, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rstrun_ready", {31'd0, cmd_tready}, 32'd1);
    drive_cmd(1'b0, 2, n0);
    push_exp(1'b0, 1'b0, n0 + 4);
    run_f(6, gc);
    check("rstrun_next_gate_cycles", gc, 32'd2);

    // Randomized commands.
    repeat (200) rand_cmd();

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_route_sched.md
DATA_ROUTE_SCHED -- requirements
Module: data_route_sched

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the beat counter and of the per-command beat count.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port cmd_tdata, input, CNT_W+1 bits: bit CNT_W is the requested mode (0 = split A/B path, 1 = C/D wide path); bits CNT_W-1:0 are the beat count on stream f.
REQ-005 The block SHALL have port cmd_tvalid, input, 1 bit: command valid.
REQ-006 The block SHALL have port cmd_tready, output, 1 bit: command ready.
REQ-007 The block SHALL have port f_fire, input, 1 bit: pulse marking one accepted beat on the f input stream (tvalid & tready).
REQ-008 The block SHALL have port c_fire, input, 1 bit: pulse marking one accepted beat on the 6144-bit C output stream.
REQ-009 The block SHALL have port abort, input, 1 bit: cancels the current command.
REQ-010 The block SHALL have port mode, output, 1 bit: registered mode select driven to the interconnect.
REQ-011 The block SHALL have port gate_en, output, 1 bit: registered enable; upstream f/g/h tvalid are qualified by it.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse on command completion.
REQ-014 The block SHALL have port err, output, 1 bit: one-cycle pulse on a rejected or aborted command.
REQ-015 The block SHALL have port beats_left, output, CNT_W bits: remaining f beats of the current command.

Function
REQ-016 The block SHALL implement states IDLE, SETUP, RUN, DRAIN, DONE; only registered outputs are permitted, with cmd_tready = (state == IDLE).
REQ-017 A command SHALL be accepted only on cmd_tvalid & cmd_tready.
REQ-018 An accepted command with count 0 SHALL go to DONE with mode unchanged, gate_en held at 0.
REQ-019 An accepted mode-1 command whose count is not a multiple of 4 SHALL pulse err on the next cycle, stay in IDLE, and leave mode unchanged.
REQ-020 An accepted valid command SHALL, at the acceptance edge, load mode, load f_left = count, load c_left = count>>2 (mode 1) or 0 (mode 0), and go to SETUP.
REQ-021 SETUP SHALL last exactly 1 cycle with gate_en = 0, so mode is stable one cycle before traffic; it then goes to RUN and sets gate_en = 1.
REQ-022 In RUN, each f_fire SHALL decrement f_left by 1.
REQ-023 An f_fire with f_left == 1 SHALL clear gate_en at that same edge, so no further beat is admitted; the next state SHALL be DRAIN if c_left is nonzero after this edge's update, otherwise DONE.
REQ-024 In RUN and DRAIN, each c_fire SHALL decrement c_left; a c_fire with c_left == 0, or in IDLE/SETUP/DONE, SHALL be ignored with no underflow.
REQ-025 A simultaneous f_fire and c_fire in the same cycle SHALL both be applied.
REQ-026 DRAIN SHALL hold gate_en = 0 and go to DONE on the edge where c_left reaches 0.
REQ-027 DONE SHALL assert done for exactly one cycle and then return to IDLE; mode SHALL be retained after DONE.
REQ-028 abort in SETUP, RUN or DRAIN SHALL, at the next edge, clear gate_en, zero f_left and c_left, pulse err, and return to IDLE; abort in IDLE or DONE SHALL be ignored.
REQ-029 The output beats_left SHALL equal f_left.

Reset
REQ-030 While rst is high, the block SHALL set state = IDLE, mode = 0, gate_en = 0, done = 0, err = 0, f_left = 0, c_left = 0; cmd_tready SHALL be 1 after release.
REQ-031 Reset mid-command SHALL discard the command with no done or err pulse.

Verification
REQ-032 Mode 0, count 3, f_fire each cycle from the first gate_en cycle -> gate_en high exactly 3 cycles, then done 1 cycle later; mode = 0.
REQ-033 Mode 1, count 8, 8 f_fire, 2 c_fire delayed by 5 cycles -> state DRAIN until the 2nd c_fire, then done; gate_en low through DRAIN.
REQ-034 Mode 1, count 6 -> err pulse, cmd_tready stays 1, mode unchanged.
REQ-035 Count 0 -> done pulse with gate_en never asserted.
REQ-036 abort after 2 of 4 beats -> gate_en 0 next cycle, err pulse, beats_left = 0, IDLE.
REQ-037 rst asserted in RUN (mode 1) -> mode = 0 and gate_en = 0 immediately; no done pulse; next command is accepted normally.
